tile_bram_arbiter: RTL and testbench

Shares one port of a dual-port tile BRAM among three requesters: the display tile fetcher (read-only, fixed latency), the host bus (Avalon-style reads/writes, writes buffered in a small queue), and a bulk clear engine that fills an address range with a constant. It drives the BRAM port through one register stage and returns read data tagged to the requester that issued the read. The other BRAM port stays free for a second client.

---
 rtl/bram_arb_pkg.sv | 17 +
 rtl/bram_wr_fifo.sv | 52 +++++
 rtl/tile_bram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_tile_bram_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared types for the tile BRAM arbiter
package bram_arb_pkg;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_DISP,
    SRC_HOST,
    SRC_CLR
  } src_t;

  typedef enum logic [1:0] {
    CLR_IDLE,
    CLR_RUN,
    CLR_DONE
  } clr_state_t;

endpackage

// File: rtl/bram_wr_fifo.sv
// rtl/bram_wr_fifo.sv - small synchronous FIFO with full/empty flags
module bram_wr_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tile_bram_arbiter.sv
// rtl/tile_bram_arbiter.sv - shares one BRAM port among display, host and clear engine
module tile_bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int ADDRESS_BITS = 10,
  parameter int QDEPTH       = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    disp_req,
  input  logic [ADDRESS_BITS-1:0] disp_addr,
  output logic                    disp_rvalid,
  output logic [DATA_BITS-1:0]    disp_rdata,
  input  logic                    host_read,
  input  logic                    host_write,
  input  logic [ADDRESS_BITS-1:0] host_addr,
  input  logic [DATA_BITS-1:0]    host_wdata,
  output logic                    host_waitrequest,
  output logic                    host_readdatavalid,
  output logic [DATA_BITS-1:0]    host_readdata,
  input  logic                    clr_start,
  input  logic [ADDRESS_BITS-1:0] clr_base,
  input  logic [ADDRESS_BITS:0]   clr_count,
  input  logic [DATA_BITS-1:0]    clr_value,
  output logic                    clr_busy,
  output logic                    clr_done,
  output logic [ADDRESS_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0]    mem_din,
  output logic                    mem_we,
  input  logic [DATA_BITS-1:0]    mem_dout
);

  localparam int QW = ADDRESS_BITS + DATA_BITS;

  logic                    q_full;
  logic                    q_empty;
  logic                    q_push;
  logic                    q_pop;
  logic [QW-1:0]           q_head;
  logic                    host_rd_ok;
  src_t                    grant;
  src_t                    tag1;
  src_t                    tag2;
  clr_state_t              clr_state;
  clr_state_t              clr_next;
  logic [ADDRESS_BITS-1:0] clr_addr;
  logic [ADDRESS_BITS:0]   clr_left;
  logic [DATA_BITS-1:0]    clr_fill;

  // A read is only taken with the queue empty so it sees every earlier host write.
  assign host_rd_ok       = host_read && q_empty && !disp_req;
  assign q_push           = host_write && !q_full;
  assign host_waitrequest = host_write ? q_full : (host_read && !host_rd_ok);

  bram_wr_fifo #(
    .WIDTH(QW),
    .DEPTH(QDEPTH)
  ) u_wr_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .din   ({host_addr, host_wdata}),
    .pop   (q_pop),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  always_comb begin
    grant = SRC_NONE;
    q_pop = 1'b0;
    if (disp_req) begin
      grant = SRC_DISP;
    end else if (!q_empty) begin
      grant = SRC_HOST;
      q_pop = 1'b1;
    end else if (host_rd_ok) begin
      grant = SRC_HOST;
    end else if (clr_state == CLR_RUN) begin
      grant = SRC_CLR;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      tag1     <= SRC_NONE;
      tag2     <= SRC_NONE;
    end else begin
      mem_we <= 1'b0;
      tag1   <= SRC_NONE;
      tag2   <= tag1;
      case (grant)
        SRC_DISP: begin
          mem_addr <= disp_addr;
          tag1     <= SRC_DISP;
        end
        SRC_HOST: begin
          if (q_pop) begin
            mem_addr <= q_head[QW-1:DATA_BITS];
            mem_din  <= q_head[DATA_BITS-1:0];
            mem_we   <= 1'b1;
          end else begin
            mem_addr <= host_addr;
            tag1     <= SRC_HOST;
          end
        end
        SRC_CLR: begin
          mem_addr <= clr_addr;
          mem_din  <= clr_fill;
          mem_we   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign disp_rvalid        = (tag2 == SRC_DISP);
  assign host_readdatavalid = (tag2 == SRC_HOST);
  assign disp_rdata         = mem_dout;
  assign host_readdata      = mem_dout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) clr_state <= CLR_IDLE;
    else       clr_state <= clr_next;
  end

  always_comb begin
    clr_next = clr_state;
    clr_busy = (clr_state != CLR_IDLE);
    clr_done = (clr_state == CLR_DONE);
    case (clr_state)
      CLR_IDLE: begin
        if (clr_start) clr_next = (clr_count == '0) ? CLR_DONE : CLR_RUN;
      end
      CLR_RUN: begin
        if (grant == SRC_CLR && clr_left == {{ADDRESS_BITS{1'b0}}, 1'b1})
          clr_next = CLR_DONE;
      end
      CLR_DONE: clr_next = CLR_IDLE;
      default:  clr_next = CLR_IDLE;
    endcase
  end

  // Address counter wraps modulo the BRAM size by its own width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_addr <= '0;
      clr_left <= '0;
      clr_fill <= '0;
    end else if (clr_state == CLR_IDLE && clr_start) begin
      clr_addr <= clr_base;
      clr_left <= clr_count;
      clr_fill <= clr_value;
    end else if (grant == SRC_CLR) begin
      clr_addr <= clr_addr + 1'b1;
      clr_left <= clr_left - 1'b1;
    end
  end

endmodule

// File: tb/tb_tile_bram_arbiter.sv
// tb/tb_tile_bram_arbiter.sv - randomized bench for tile_bram_arbiter with a shadow-memory model
module tb_tile_bram_arbiter;

  localparam int DB   = 8;
  localparam int AB   = 10;
  localparam int QD   = 4;
  localparam int LOGN = 16384;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          disp_req = 1'b0;
  logic [AB-1:0] disp_addr = '0;
  logic          disp_rvalid;
  logic [DB-1:0] disp_rdata;
  logic          host_read = 1'b0;
  logic          host_write = 1'b0;
  logic [AB-1:0] host_addr = '0;
  logic [DB-1:0] host_wdata = '0;
  logic          host_waitrequest;
  logic          host_readdatavalid;
  logic [DB-1:0] host_readdata;
  logic          clr_start = 1'b0;
  logic [AB-1:0] clr_base = '0;
  logic [AB:0]   clr_count = '0;
  logic [DB-1:0] clr_value = '0;
  logic          clr_busy;
  logic          clr_done;
  logic [AB-1:0] mem_addr;
  logic [DB-1:0] mem_din;
  logic          mem_we;
  logic [DB-1:0] mem_dout;

  logic [DB-1:0] bram   [1<<AB];
  logic [DB-1:0] shadow [1<<AB];

  logic          we_l   [LOGN];
  logic [AB-1:0] addr_l [LOGN];
  logic [DB-1:0] din_l  [LOGN];
  logic          dreq_l [LOGN];
  logic          hacc_l [LOGN];
  logic          drv_l  [LOGN];
  logic [DB-1:0] drd_l  [LOGN];
  logic          hrv_l  [LOGN];
  logic [DB-1:0] hrd_l  [LOGN];
  logic          done_l [LOGN];
  logic          busy_l [LOGN];

  int cyc = 0;
  int vectors = 0;
  int errors = 0;

  tile_bram_arbiter #(.DATA_BITS(DB), .ADDRESS_BITS(AB), .QDEPTH(QD)) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .host_read(host_read), .host_write(host_write), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_waitrequest(host_waitrequest), .host_readdatavalid(host_readdatavalid),
    .host_readdata(host_readdata),
    .clr_start(clr_start), .clr_base(clr_base), .clr_count(clr_count), .clr_value(clr_value),
    .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM port model: read data appears one cycle after the address.
  always @(posedge clk) begin
    if (mem_we) bram[mem_addr] <= mem_din;
    mem_dout <= bram[mem_addr];
  end

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      we_l[cyc]   = mem_we;
      addr_l[cyc] = mem_addr;
      din_l[cyc]  = mem_din;
      dreq_l[cyc] = disp_req;
      hacc_l[cyc] = host_write && !host_waitrequest;
      drv_l[cyc]  = disp_rvalid;
      drd_l[cyc]  = disp_rdata;
      hrv_l[cyc]  = host_readdatavalid;
      hrd_l[cyc]  = host_readdata;
      done_l[cyc] = clr_done;
      busy_l[cyc] = clr_busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int k);
    while (cyc <= k) tick();
  endtask

  task automatic host_wr(input logic [AB-1:0] a, input logic [DB-1:0] d, output int acc);
    acc = -1;
    host_write = 1'b1; host_addr = a; host_wdata = d;
    for (int i = 0; i < 200 && acc < 0; i++) begin
      @(negedge clk);
      if (!host_waitrequest) acc = cyc;
      tick();
    end
    host_write = 1'b0;
    vectors++;
    if (acc < 0) begin errors++; $display("FAIL host_wr_accept addr %0d never accepted", a); end
    else shadow[a] = d;
  endtask

  task automatic host_rd(input logic [AB-1:0] a, output int ra);
    ra = -1;
    host_read = 1'b1; host_addr = a;
    for (int i = 0; i < 200 && ra < 0; i++) begin
      @(negedge clk);
      if (!host_waitrequest) ra = cyc;
      tick();
    end
    host_read = 1'b0;
    vectors++;
    if (ra < 0) begin errors++; $display("FAIL host_rd_accept addr %0d never accepted", a); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors += 8;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %0d want 0", mem_addr); end
    if (mem_din !== '0) begin errors++; $display("FAIL reset_mem_din got %0d want 0", mem_din); end
    if (disp_rvalid !== 1'b0) begin errors++; $display("FAIL reset_disp_rvalid got %b want 0", disp_rvalid); end
    if (host_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_host_rdv got %b want 0", host_readdatavalid); end
    if (host_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_waitreq got %b want 0", host_waitrequest); end
    if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_clr_busy got %b want 0", clr_busy); end
    if (clr_done !== 1'b0) begin errors++; $display("FAIL reset_clr_done got %b want 0", clr_done); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_clear_wrap();
    int s, nbad;
    logic [AB-1:0] ea, base;
    logic [DB-1:0] v;
    s = cyc; clr_base = AB'(1020); clr_count = (AB+1)'(8); clr_value = 8'hFF; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    wait_until(s + 10);
    vectors++;
    if (busy_l[s+1] !== 1'b1) begin errors++; $display("FAIL wrap_busy_start got %b want 1", busy_l[s+1]); end
    for (int i = 0; i < 8; i++) begin
      ea = AB'(1020 + i);
      vectors++;
      if (we_l[s+2+i] !== 1'b1 || addr_l[s+2+i] !== ea || din_l[s+2+i] !== 8'hFF) begin
        errors++;
        $display("FAIL wrap_write%0d got we=%b addr=%0d din=%h want we=1 addr=%0d din=ff", i, we_l[s+2+i], addr_l[s+2+i], din_l[s+2+i], ea);
      end
      shadow[ea] = 8'hFF;
    end
    vectors += 4;
    if (done_l[s+8] !== 1'b0) begin errors++; $display("FAIL wrap_done_early got %b want 0", done_l[s+8]); end
    if (done_l[s+9] !== 1'b1) begin errors++; $display("FAIL wrap_done got %b want 1", done_l[s+9]); end
    if (done_l[s+10] !== 1'b0) begin errors++; $display("FAIL wrap_done_width got %b want 0", done_l[s+10]); end
    if (busy_l[s+10] !== 1'b0) begin errors++; $display("FAIL wrap_busy_end got %b want 0", busy_l[s+10]); end

    s = cyc; clr_count = '0; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    wait_until(s + 3);
    vectors += 3;
    if (done_l[s+1] !== 1'b1 || busy_l[s+1] !== 1'b1) begin errors++; $display("FAIL zero_done got done=%b busy=%b want 1 1", done_l[s+1], busy_l[s+1]); end
    if (busy_l[s+2] !== 1'b0) begin errors++; $display("FAIL zero_busy_end got %b want 0", busy_l[s+2]); end
    if ((we_l[s+1] | we_l[s+2]) !== 1'b0) begin errors++; $display("FAIL zero_no_write got %b want 0", we_l[s+1] | we_l[s+2]); end

    base = AB'($urandom); v = DB'($urandom);
    s = cyc; clr_base = base; clr_count = (AB+1)'(1 << AB); clr_value = v; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    wait_until(s + 1027);
    nbad = 0;
    for (int i = 0; i < (1 << AB); i++)
      if (we_l[s+2+i] !== 1'b1 || addr_l[s+2+i] !== AB'(base + i) || din_l[s+2+i] !== v) nbad++;
    for (int i = 0; i < (1 << AB); i++) shadow[i] = v;
    vectors += 2;
    if (nbad != 0) begin errors++; $display("FAIL full_clear_writes got %0d bad cycles want 0", nbad); end
    if (done_l[s+1025] !== 1'b1 || done_l[s+1024] !== 1'b0) begin errors++; $display("FAIL full_clear_done got %b%b want 01", done_l[s+1024], done_l[s+1025]); end
  endtask

  task automatic test_disp_burst();
    int acc, t0;
    host_wr(AB'(5), 8'hA5, acc);
    host_wr(AB'(6), 8'hA6, acc);
    host_wr(AB'(7), 8'hA7, acc);
    repeat (4) tick();
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      disp_req = 1'b1; disp_addr = AB'(5 + i);
      tick();
    end
    disp_req = 1'b0;
    wait_until(t0 + 5);
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (drv_l[t0+k] !== (k >= 2 && k <= 4)) begin
        errors++; $display("FAIL disp_rvalid_t+%0d got %b want %b", k, drv_l[t0+k], (k >= 2 && k <= 4));
      end
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (drd_l[t0+2+i] !== shadow[5+i]) begin
        errors++; $display("FAIL disp_rdata%0d got %h want %h", i, drd_l[t0+2+i], shadow[5+i]);
      end
    end
  endtask

  task automatic test_queue_full();
    logic [AB-1:0] qa [5];
    logic [DB-1:0] qd [5];
    int td;
    for (int i = 0; i < 5; i++) begin qa[i] = AB'($urandom); qd[i] = DB'($urandom); end
    disp_req = 1'b1; disp_addr = AB'($urandom);
    for (int i = 0; i < 4; i++) begin
      host_write = 1'b1; host_addr = qa[i]; host_wdata = qd[i];
      @(negedge clk);
      vectors++;
      if (host_waitrequest !== 1'b0) begin errors++; $display("FAIL qfull_accept%0d waitreq got %b want 0", i, host_waitrequest); end
      shadow[qa[i]] = qd[i];
      tick();
    end
    host_addr = qa[4]; host_wdata = qd[4];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (host_waitrequest !== 1'b1) begin errors++; $display("FAIL qfull_stall%0d waitreq got %b want 1", i, host_waitrequest); end
      tick();
    end
    disp_req = 1'b0; td = cyc;
    @(negedge clk);
    vectors++;
    if (host_waitrequest !== 1'b1) begin errors++; $display("FAIL qfull_drain_first waitreq got %b want 1", host_waitrequest); end
    tick();
    @(negedge clk);
    vectors++;
    if (host_waitrequest !== 1'b0) begin errors++; $display("FAIL qfull_fifth_accept waitreq got %b want 0", host_waitrequest); end
    shadow[qa[4]] = qd[4];
    tick();
    host_write = 1'b0;
    wait_until(td + 6);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (we_l[td+1+i] !== 1'b1 || addr_l[td+1+i] !== qa[i] || din_l[td+1+i] !== qd[i]) begin
        errors++;
        $display("FAIL qfull_drain%0d got we=%b addr=%0d din=%h want we=1 addr=%0d din=%h", i, we_l[td+1+i], addr_l[td+1+i], din_l[td+1+i], qa[i], qd[i]);
      end
    end
    vectors++;
    if (we_l[td+6] !== 1'b0) begin errors++; $display("FAIL qfull_drain_end we got %b want 0", we_l[td+6]); end
  endtask

  task automatic test_write_then_read();
    int acc, ra;
    logic [AB-1:0] a;
    logic [DB-1:0] d;
    for (int it = 0; it < 4; it++) begin
      a = (it == 0) ? AB'(9) : AB'($urandom);
      d = (it == 0) ? 8'h3C : DB'($urandom);
      host_wr(a, d, acc);
      host_rd(a, ra);
      if (ra >= 0 && acc >= 0) begin
        wait_until(ra + 3);
        vectors += 3;
        if (ra != acc + 2) begin errors++; $display("FAIL rd_after_wr%0d accept cycle got %0d want %0d", it, ra, acc + 2); end
        if (hrv_l[ra+1] !== 1'b0 || hrv_l[ra+2] !== 1'b1 || hrv_l[ra+3] !== 1'b0) begin
          errors++; $display("FAIL rd_latency%0d got %b%b%b want 010", it, hrv_l[ra+1], hrv_l[ra+2], hrv_l[ra+3]);
        end
        if (hrd_l[ra+2] !== shadow[a]) begin errors++; $display("FAIL rd_data%0d got %h want %h", it, hrd_l[ra+2], shadow[a]); end
      end
    end
  endtask

  task automatic test_clear_contention();
    logic [AB-1:0] base, ha;
    logic [DB-1:0] v;
    logic [AB-1:0] hq [$];
    logic [AB-1:0] rl [$];
    int s, e, t0, nclr, nbad, accs, hw, vbad;
    logic done_seen, took;
    base = AB'($urandom); v = DB'($urandom);
    s = cyc; clr_base = base; clr_count = (AB+1)'(16); clr_value = v; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    done_seen = 1'b0;
    for (int n = 0; n < 400 && !(done_seen && n >= 40); n++) begin
      if (!host_write && $urandom_range(0, 3) == 0) begin
        do ha = AB'($urandom); while (AB'(ha - base) < AB'(16));
        host_write = 1'b1; host_addr = ha; host_wdata = DB'($urandom);
      end
      disp_req = 1'($urandom_range(0, 1)); disp_addr = AB'($urandom);
      @(negedge clk);
      if (clr_done) done_seen = 1'b1;
      took = host_write && !host_waitrequest;
      if (took) begin shadow[host_addr] = host_wdata; hq.push_back(host_addr); end
      tick();
      if (took) host_write = 1'b0;
    end
    host_write = 1'b0; disp_req = 1'b0;
    repeat (8) tick();
    e = cyc;
    vectors++;
    if (!done_seen) begin errors++; $display("FAIL contend_done got 0 want 1"); end
    nclr = 0; nbad = 0; accs = 0; hw = 0;
    for (int c = s + 1; c < e; c++) begin
      if (c - 2 >= s && hacc_l[c-2] === 1'b1) accs++;
      if (we_l[c] === 1'b1 && AB'(addr_l[c] - base) < AB'(16)) begin
        if (addr_l[c] !== AB'(base + nclr) || din_l[c] !== v || dreq_l[c-1] !== 1'b0 || accs != hw) nbad++;
        nclr++;
      end else if (we_l[c] === 1'b1) begin
        hw++;
      end
    end
    vectors++;
    if (nclr != 16 || nbad != 0) begin errors++; $display("FAIL contend_clear_writes got %0d writes %0d bad want 16 writes 0 bad", nclr, nbad); end
    vbad = 0;
    for (int k = s + 2; k < e; k++) if (drv_l[k] !== dreq_l[k-2]) vbad++;
    vectors++;
    if (vbad != 0) begin errors++; $display("FAIL contend_disp_latency got %0d bad cycles want 0", vbad); end
    for (int i = 0; i < 16; i++) begin
      ha = AB'(base + i);
      rl.push_back(ha);
      shadow[ha] = v;
    end
    foreach (hq[i]) rl.push_back(hq[i]);
    t0 = cyc;
    foreach (rl[i]) begin disp_req = 1'b1; disp_addr = rl[i]; tick(); end
    disp_req = 1'b0;
    wait_until(t0 + rl.size() + 2);
    foreach (rl[i]) begin
      vectors++;
      if (drv_l[t0+2+i] !== 1'b1 || drd_l[t0+2+i] !== shadow[rl[i]]) begin
        errors++;
        $display("FAIL contend_readback addr %0d got valid=%b data=%h want valid=1 data=%h", rl[i], drv_l[t0+2+i], drd_l[t0+2+i], shadow[rl[i]]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int s, rc, r, acc, nbad;
    logic [AB-1:0] base;
    logic [DB-1:0] v;
    clr_base = AB'($urandom); clr_count = (AB+1)'(200); clr_value = DB'($urandom); clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (5) tick();
    disp_req = 1'b1; disp_addr = AB'($urandom);
    host_wr(AB'($urandom), DB'($urandom), acc);
    host_wr(AB'($urandom), DB'($urandom), acc);
    #2;
    rc = cyc;
    reset = 1'b1; disp_req = 1'b0;
    #1;
    vectors += 8;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL midrst_mem_we got %b want 0", mem_we); end
    if (mem_addr !== '0) begin errors++; $display("FAIL midrst_mem_addr got %0d want 0", mem_addr); end
    if (mem_din !== '0) begin errors++; $display("FAIL midrst_mem_din got %0d want 0", mem_din); end
    if (disp_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_disp_rvalid got %b want 0", disp_rvalid); end
    if (host_readdatavalid !== 1'b0) begin errors++; $display("FAIL midrst_host_rdv got %b want 0", host_readdatavalid); end
    if (host_waitrequest !== 1'b0) begin errors++; $display("FAIL midrst_waitreq got %b want 0", host_waitrequest); end
    if (clr_busy !== 1'b0) begin errors++; $display("FAIL midrst_clr_busy got %b want 0", clr_busy); end
    if (clr_done !== 1'b0) begin errors++; $display("FAIL midrst_clr_done got %b want 0", clr_done); end
    repeat (3) tick();
    reset = 1'b0; r = cyc;
    wait_until(r + 9);
    nbad = 0;
    for (int k = rc; k <= r + 8; k++) if (we_l[k] !== 1'b0 || done_l[k] !== 1'b0 || busy_l[k] !== 1'b0) nbad++;
    vectors++;
    if (nbad != 0) begin errors++; $display("FAIL midrst_quiet got %0d active cycles want 0", nbad); end
    base = AB'($urandom); v = DB'($urandom);
    s = cyc; clr_base = base; clr_count = (AB+1)'(3); clr_value = v; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    wait_until(s + 6);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (we_l[s+2+i] !== 1'b1 || addr_l[s+2+i] !== AB'(base + i) || din_l[s+2+i] !== v) begin
        errors++;
        $display("FAIL restart_write%0d got we=%b addr=%0d din=%h want we=1 addr=%0d din=%h", i, we_l[s+2+i], addr_l[s+2+i], din_l[s+2+i], AB'(base + i), v);
      end
    end
    vectors++;
    if (done_l[s+4] !== 1'b1 || done_l[s+5] !== 1'b0 || busy_l[s+5] !== 1'b0) begin
      errors++; $display("FAIL restart_done got done=%b%b busy=%b want done=10 busy=0", done_l[s+4], done_l[s+5], busy_l[s+5]);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AB); i++) begin bram[i] = '0; shadow[i] = '0; end
    test_reset();
    test_clear_wrap();
    test_disp_burst();
    test_queue_full();
    test_write_then_read();
    test_clear_contention();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
